// File: rtl/minmax_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : minmax_tracker
//  Purpose  : Running signed max/min tracker over a valid/ready sample stream.
//             Each sample after the first is compared against the stored
//             maximum and then against the stored minimum. The comparison is
//             done by an external N-bit comparator that this block drives
//             (cmp_x/cmp_y) and reads back (V/N/Z flags of X-Y).
//  Ports    :
//    clk, rst_n           clock, asynchronous active-low reset
//    clear                synchronous window restart
//    in_valid/in_ready    sample handshake (ready only in IDLE)
//    in_data  [N]         two's-complement sample
//    cmp_x/cmp_y [N]      comparator operands (sample, stored max/min)
//    cmp_v/cmp_n/cmp_z    comparator flags of cmp_x - cmp_y
//    max_out/min_out [N]  running signed extremes
//    count [CNT_W]        samples accepted, saturating
//    sat                  count is at its maximum value
//    stats_valid          outputs are stable and reflect >= 1 sample
//  Revision : 1.0  initial release
// ============================================================================
module minmax_tracker #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic [N-1:0]     cmp_x,
    output logic [N-1:0]     cmp_y,
    input  logic             cmp_v,
    input  logic             cmp_n,
    input  logic             cmp_z,
    output logic [N-1:0]     max_out,
    output logic [N-1:0]     min_out,
    output logic [CNT_W-1:0] count,
    output logic             sat,
    output logic             stats_valid
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMP_MAX = 2'd1,
        ST_CMP_MIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    state_t           r_state;
    state_t           w_next_state;
    logic [N-1:0]     r_samp;
    logic [N-1:0]     r_max;
    logic [N-1:0]     r_min;
    logic [CNT_W-1:0] r_count;

    logic             w_lt;
    logic             w_gt;
    logic             w_first;

    // Signed decode of the X-Y flags: overflow flips the sign of the result.
    assign w_lt    = cmp_n ^ cmp_v;
    assign w_gt    = !w_lt && !cmp_z;
    assign w_first = (r_count == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                // The first sample of a window seeds both extremes directly,
                // so no compare pass is needed for it.
                if (in_valid && !w_first) begin
                    w_next_state = ST_CMP_MAX;
                end
            end
            ST_CMP_MAX: w_next_state = ST_CMP_MIN;
            ST_CMP_MIN: w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp  <= '0;
            r_max   <= '0;
            r_min   <= '0;
            r_count <= '0;
        end else if (clear) begin
            // Clearing mid-compare discards the in-flight sample entirely.
            r_samp  <= '0;
            r_max   <= '0;
            r_min   <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_samp <= in_data;
                        if (w_first) begin
                            r_max   <= in_data;
                            r_min   <= in_data;
                            r_count <= CNT_W'(1);
                        end
                    end
                end
                ST_CMP_MAX: begin
                    if (w_gt) begin
                        r_max <= r_samp;
                    end
                end
                ST_CMP_MIN: begin
                    if (w_lt) begin
                        r_min <= r_samp;
                    end
                    if (r_count != C_CNT_MAX) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                default: begin
                    r_samp <= r_samp;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Y operand shows the stored max in IDLE and CMP_MAX, min only in CMP_MIN.
    assign cmp_x       = r_samp;
    assign cmp_y       = (r_state == ST_CMP_MIN) ? r_min : r_max;
    assign in_ready    = (r_state == ST_IDLE);
    assign max_out     = r_max;
    assign min_out     = r_min;
    assign count       = r_count;
    assign sat         = (r_count == C_CNT_MAX);
    assign stats_valid = (r_state == ST_IDLE) && !w_first;

endmodule
`default_nettype wire

// File: tb/tb_minmax_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_minmax_tracker
//  Purpose  : Scoreboard bench for minmax_tracker. Two instances: default
//             widths, and CNT_W=2 for saturation. Each instance is wired to a
//             behavioural N-bit comparator producing V/N/Z of X-Y.
//  Revision : 1.0  initial release
// ============================================================================
module tb_minmax_tracker;

    typedef struct packed {
        logic [3:0] mx;
        logic [3:0] mn;
        logic [7:0] cnt;
        logic       st;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Instance 1 (CNT_W = 8)
    logic       clear1    = 1'b0;
    logic       in_valid1 = 1'b0;
    logic [3:0] in_data1  = 4'h0;
    logic       in_ready1;
    logic [3:0] cmp_x1, cmp_y1, max1, min1;
    logic       cmp_v1, cmp_n1, cmp_z1, sat1, sv1;
    logic [7:0] count1;

    // Instance 2 (CNT_W = 2)
    logic       clear2    = 1'b0;
    logic       in_valid2 = 1'b0;
    logic [3:0] in_data2  = 4'h0;
    logic       in_ready2;
    logic [3:0] cmp_x2, cmp_y2, max2, min2;
    logic       cmp_v2, cmp_n2, cmp_z2, sat2, sv2;
    logic [1:0] count2;

    int   errors = 0;
    int   checks = 0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    // Behavioural comparator: flags of X - Y in 4-bit two's complement.
    logic [3:0] diff1, diff2;
    assign diff1  = cmp_x1 - cmp_y1;
    assign cmp_n1 = diff1[3];
    assign cmp_z1 = (diff1 == 4'h0);
    assign cmp_v1 = (cmp_x1[3] != cmp_y1[3]) && (diff1[3] != cmp_x1[3]);
    assign diff2  = cmp_x2 - cmp_y2;
    assign cmp_n2 = diff2[3];
    assign cmp_z2 = (diff2 == 4'h0);
    assign cmp_v2 = (cmp_x2[3] != cmp_y2[3]) && (diff2[3] != cmp_x2[3]);

    minmax_tracker #(.N(4), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .cmp_x(cmp_x1), .cmp_y(cmp_y1),
        .cmp_v(cmp_v1), .cmp_n(cmp_n1), .cmp_z(cmp_z1),
        .max_out(max1), .min_out(min1), .count(count1),
        .sat(sat1), .stats_valid(sv1)
    );

    minmax_tracker #(.N(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .cmp_x(cmp_x2), .cmp_y(cmp_y2),
        .cmp_v(cmp_v2), .cmp_n(cmp_n2), .cmp_z(cmp_z2),
        .max_out(max2), .min_out(min2), .count(count2),
        .sat(sat2), .stats_valid(sv2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitors: a completed result is signalled by stats_valid rising.
    logic prev1 = 1'b0;
    logic prev2 = 1'b0;
    always @(negedge clk) begin
        if (sv1 && !prev1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb1_unexpected: got result %0h with nothing expected",
                         {max1, min1, count1, sat1});
            end else begin
                chk("sb1_result", {15'd0, max1, min1, count1, sat1}, {15'd0, q1.pop_front()});
            end
        end
        if (sv2 && !prev2) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb2_unexpected: got result %0h with nothing expected",
                         {max2, min2, count2, sat2});
            end else begin
                chk("sb2_result", {15'd0, max2, min2, 6'd0, count2, sat2}, {15'd0, q2.pop_front()});
            end
        end
        prev1 = sv1;
        prev2 = sv2;
    end

    // Offer a sample (in_valid left high for streaming), check how many
    // cycles in_ready was low before acceptance, and queue the expectation.
    task automatic send(input logic [3:0] d, input bit sel, input int exp_wait, input exp_t e);
        int w;
        w = 0;
        if (!sel) begin in_data1 = d; in_valid1 = 1'b1; end
        else      begin in_data2 = d; in_valid2 = 1'b1; end
        while (!(sel ? in_ready2 : in_ready1) && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk(sel ? "ready_wait2" : "ready_wait1", w, exp_wait);
        if (!sel) q1.push_back(e);
        else      q2.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_out();
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- Reset ----------------
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_max",   max1,   4'h0);
        chk("rst_min",   min1,   4'h0);
        chk("rst_count", count1, 8'h0);
        chk("rst_sat",   sat1,   1'b0);
        chk("rst_cmp_x", cmp_x1, 4'h0);
        chk("rst_cmp_y", cmp_y1, 4'h0);
        chk("rst_sv",    sv1,    1'b0);
        chk("rst_ready", in_ready1, 1'b1);
        chk("rst_count2", count2, 2'h0);

        // ---------------- Stream 3, -2, 5, 5, -2 ----------------
        send(4'h3, 0, 0, {4'h3, 4'h3, 8'd1, 1'b0});
        send(4'hE, 0, 0, {4'h3, 4'hE, 8'd2, 1'b0});
        send(4'h5, 0, 2, {4'h5, 4'hE, 8'd3, 1'b0});
        send(4'h5, 0, 2, {4'h5, 4'hE, 8'd4, 1'b0});
        send(4'hE, 0, 2, {4'h5, 4'hE, 8'd5, 1'b0});
        idle_out();

        // ---------------- Overflow path: 1, -8, 7, -8 ----------------
        clear1 = 1'b1;
        @(negedge clk);
        clear1 = 1'b0;
        send(4'h1, 0, 0, {4'h1, 4'h1, 8'd1, 1'b0});
        send(4'h8, 0, 0, {4'h1, 4'h8, 8'd2, 1'b0});
        send(4'h7, 0, 2, {4'h7, 4'h8, 8'd3, 1'b0});
        send(4'h8, 0, 2, {4'h7, 4'h8, 8'd4, 1'b0});
        idle_out();

        // ---------------- Clear during CMP_MAX ----------------
        clear1 = 1'b1;
        @(negedge clk);
        clear1 = 1'b0;
        send(4'h2, 0, 0, {4'h2, 4'h2, 8'd1, 1'b0});
        in_data1  = 4'h3;
        in_valid1 = 1'b1;
        @(negedge clk);                    // 3 accepted, now in CMP_MAX
        chk("cmpmax_ready", in_ready1, 1'b0);
        clear1   = 1'b1;
        in_data1 = 4'h4;                   // pending sample, must be dropped
        @(negedge clk);
        clear1    = 1'b0;
        in_valid1 = 1'b0;
        chk("clr_count", count1, 8'h0);
        chk("clr_sv",    sv1,    1'b0);
        chk("clr_max",   max1,   4'h0);
        chk("clr_min",   min1,   4'h0);
        chk("clr_ready", in_ready1, 1'b1);
        repeat (2) @(negedge clk);
        chk("clr_hold_count", count1, 8'h0);
        send(4'h6, 0, 0, {4'h6, 4'h6, 8'd1, 1'b0});
        idle_out();

        // ---------------- Saturation, CNT_W=2: 1,2,3,4,-1 ----------------
        send(4'h1, 1, 0, {4'h1, 4'h1, 8'd1, 1'b0});
        send(4'h2, 1, 0, {4'h2, 4'h1, 8'd2, 1'b0});
        send(4'h3, 1, 2, {4'h3, 4'h1, 8'd3, 1'b1});
        send(4'h4, 1, 2, {4'h4, 4'h1, 8'd3, 1'b1});
        send(4'hF, 1, 2, {4'h4, 4'hF, 8'd3, 1'b1});
        idle_out();

        // ---------------- Async reset during CMP_MIN ----------------
        send(4'h1, 0, 0, {4'h6, 4'h1, 8'd2, 1'b0});
        idle_out();
        in_data1  = 4'h2;
        in_valid1 = 1'b1;
        @(negedge clk);                    // accepted, now in CMP_MAX
        in_valid1 = 1'b0;
        @(posedge clk);                    // now in CMP_MIN
        #2;
        chk("pre_arst_cmp_y", cmp_y1, 4'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_max",   max1,   4'h0);
        chk("arst_min",   min1,   4'h0);
        chk("arst_count", count1, 8'h0);
        chk("arst_cmp_x", cmp_x1, 4'h0);
        chk("arst_cmp_y", cmp_y1, 4'h0);
        chk("arst_count2", count2, 2'h0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("arst_ready", in_ready1, 1'b1);
        chk("arst_count_rel", count1, 8'h0);
        chk("arst_sv", sv1, 1'b0);
        repeat (3) @(negedge clk);

        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
